// File: rtl/seq_hit_logger.sv
// Timestamped hit logger: captures rising edges of a sequence-detector flag into a FIFO.
// Optional registered occupancy interrupt is enabled with macro SEQ_HIT_LOGGER_IRQ_EN.
module seq_hit_logger #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TS_W    = 12,
  parameter int unsigned IRQ_THR = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hit,
  input  logic            clr,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [TS_W-1:0] out_ts,
  output logic            ovf,
  output logic [7:0]      hit_cnt
`ifdef SEQ_HIT_LOGGER_IRQ_EN
  ,
  output logic            irq
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Elaboration-time parameter sanity checks
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("seq_hit_logger: DEPTH must be a power of two in 2..16");
  end
  if (IRQ_THR > DEPTH) begin : g_bad_thr
    $error("seq_hit_logger: IRQ_THR must not exceed DEPTH");
  end

  logic [TS_W-1:0]  ts;
  logic             hit_q;
  logic [TS_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             evt_c;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;
  logic [PTR_W-1:0] rd_ptr_nxt_c;
  logic [CNT_W-1:0] count_nxt_c;
  logic [TS_W-1:0]  head_nxt_c;

  // Next-state decode: a push while full is only accepted if the head leaves this cycle
  always_comb begin
    evt_c        = hit & ~hit_q;
    pop_c        = out_valid & out_ready;
    push_c       = evt_c & ((count != FULL_CNT) | pop_c);
    drop_c       = evt_c & ~push_c;
    rd_ptr_nxt_c = rd_ptr;
    count_nxt_c  = count;
    if (pop_c) begin
      rd_ptr_nxt_c = rd_ptr + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_nxt_c = count + CNT_W'(1);
      2'b01:   count_nxt_c = count - CNT_W'(1);
      default: count_nxt_c = count;
    endcase
    // Head about to be written this edge is forwarded straight from ts
    if (push_c && (wr_ptr == rd_ptr_nxt_c)) begin
      head_nxt_c = ts;
    end else begin
      head_nxt_c = mem[rd_ptr_nxt_c];
    end
  end

  // Storage array needs no reset; occupancy alone defines which entries are live
  always_ff @(posedge clk) begin
    if (!reset && push_c) begin
      mem[wr_ptr] <= ts;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts        <= '0;
      hit_q     <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_ts    <= '0;
      ovf       <= 1'b0;
      hit_cnt   <= '0;
    end else begin
      ts        <= ts + TS_W'(1);
      hit_q     <= hit;
      rd_ptr    <= rd_ptr_nxt_c;
      count     <= count_nxt_c;
      out_valid <= (count_nxt_c != '0);
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (count_nxt_c != '0) begin
        out_ts <= head_nxt_c;
      end
      // An event in the same cycle as clr takes precedence over the clear
      if (drop_c) begin
        ovf <= 1'b1;
      end else if (clr) begin
        ovf <= 1'b0;
      end
      if (evt_c) begin
        if (clr) begin
          hit_cnt <= 8'd1;
        end else if (hit_cnt != 8'hFF) begin
          hit_cnt <= hit_cnt + 8'd1;
        end
      end else if (clr) begin
        hit_cnt <= '0;
      end
    end
  end

`ifdef SEQ_HIT_LOGGER_IRQ_EN
  // Alert follows registered occupancy, so it lags occupancy changes by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= (count >= CNT_W'(IRQ_THR));
    end
  end
`endif

endmodule

// File: tb/tb_seq_hit_logger.sv
// Directed bench for seq_hit_logger (default parameters, DEPTH=4, TS_W=12, IRQ_THR=2).
module tb_seq_hit_logger;

  logic        clk;
  logic        reset;
  logic        hit;
  logic        clr;
  logic        out_ready;
  logic        out_valid;
  logic [11:0] out_ts;
  logic        ovf;
  logic [7:0]  hit_cnt;
`ifdef SEQ_HIT_LOGGER_IRQ_EN
  logic        irq;
`endif

  int pass_cnt;
  int total_cnt;

  seq_hit_logger #(.DEPTH(4), .TS_W(12), .IRQ_THR(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .hit       (hit),
    .clr       (clr),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_ts    (out_ts),
    .ovf       (ovf),
    .hit_cnt   (hit_cnt)
`ifdef SEQ_HIT_LOGGER_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; hit = 1'b0; clr = 1'b0; out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // One-cycle hit pulse followed by one idle cycle
  task automatic pulse();
    hit = 1'b1;
    step();
    hit = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; hit = 1'b1; clr = 1'b0; out_ready = 1'b0;
    step();
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", out_valid); else pass_cnt++;
    total_cnt++;
    if (out_ts !== 12'd0) $display("FAIL reset_ts: got %0d want 0", out_ts); else pass_cnt++;
    total_cnt++;
    if (ovf !== 1'b0) $display("FAIL reset_ovf: got %0b want 0", ovf); else pass_cnt++;
    total_cnt++;
    if (hit_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", hit_cnt); else pass_cnt++;
`ifdef SEQ_HIT_LOGGER_IRQ_EN
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %0b want 0", irq); else pass_cnt++;
`endif
    // hit still high on the first free cycle counts as a rising edge at ts=0
    reset = 1'b0;
    step();
    hit = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL post_reset_valid: got %0b want 1", out_valid); else pass_cnt++;
    total_cnt++;
    if (out_ts !== 12'd0) $display("FAIL post_reset_ts: got %0d want 0", out_ts); else pass_cnt++;
    total_cnt++;
    if (hit_cnt !== 8'd1) $display("FAIL post_reset_cnt: got %0d want 1", hit_cnt); else pass_cnt++;
  endtask

  task automatic test_single_pulse();
    do_reset();
    repeat (5) step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL single_idle_valid: got %0b want 0", out_valid); else pass_cnt++;
    hit = 1'b1;
    step();
    hit = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL single_valid: got %0b want 1", out_valid); else pass_cnt++;
    total_cnt++;
    if (out_ts !== 12'd5) $display("FAIL single_ts: got %0d want 5", out_ts); else pass_cnt++;
    total_cnt++;
    if (hit_cnt !== 8'd1) $display("FAIL single_cnt: got %0d want 1", hit_cnt); else pass_cnt++;
  endtask

  task automatic test_held_high();
    do_reset();
    hit = 1'b1;
    repeat (6) step();
    hit = 1'b0;
    step();
    total_cnt++;
    if (hit_cnt !== 8'd1) $display("FAIL held_cnt: got %0d want 1", hit_cnt); else pass_cnt++;
    total_cnt++;
    if (out_ts !== 12'd0) $display("FAIL held_ts: got %0d want 0", out_ts); else pass_cnt++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL held_one_entry: got %0b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_empty_push_pop();
    do_reset();
    out_ready = 1'b1;
    hit = 1'b1;
    step();
    hit = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || out_ts !== 12'd0)
      $display("FAIL empty_push: got valid=%0b ts=%0d want valid=1 ts=0", out_valid, out_ts);
    else pass_cnt++;
    step();
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL empty_drain: got %0b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [11:0] exp_ts;
    do_reset();
    repeat (5) pulse();
    total_cnt++;
    if (ovf !== 1'b1) $display("FAIL ovf_set: got %0b want 1", ovf); else pass_cnt++;
    total_cnt++;
    if (hit_cnt !== 8'd5) $display("FAIL ovf_cnt: got %0d want 5", hit_cnt); else pass_cnt++;
    clr = 1'b1;
    step();
    clr = 1'b0;
    total_cnt++;
    if (ovf !== 1'b0 || hit_cnt !== 8'd0)
      $display("FAIL clr: got ovf=%0b cnt=%0d want ovf=0 cnt=0", ovf, hit_cnt);
    else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_ts = 12'(2 * i);
      total_cnt++;
      if (out_valid !== 1'b1 || out_ts !== exp_ts)
        $display("FAIL ovf_drain%0d: got valid=%0b ts=%0d want valid=1 ts=%0d", i, out_valid, out_ts, exp_ts);
      else pass_cnt++;
      step();
    end
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL ovf_empty: got %0b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    logic [11:0] exp_ts;
    do_reset();
    repeat (4) pulse();
    hit = 1'b1;
    out_ready = 1'b1;
    step();
    hit = 1'b0;
    out_ready = 1'b0;
    total_cnt++;
    if (ovf !== 1'b0) $display("FAIL full_pop_ovf: got %0b want 0", ovf); else pass_cnt++;
    total_cnt++;
    if (hit_cnt !== 8'd5) $display("FAIL full_pop_cnt: got %0d want 5", hit_cnt); else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_ts = 12'(2 * (i + 1));
      total_cnt++;
      if (out_valid !== 1'b1 || out_ts !== exp_ts)
        $display("FAIL full_pop_drain%0d: got valid=%0b ts=%0d want valid=1 ts=%0d", i, out_valid, out_ts, exp_ts);
      else pass_cnt++;
      step();
    end
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL full_pop_empty: got %0b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_clr_with_event();
    do_reset();
    repeat (4) pulse();
    hit = 1'b1;
    clr = 1'b1;
    step();
    hit = 1'b0;
    clr = 1'b0;
    total_cnt++;
    if (ovf !== 1'b1 || hit_cnt !== 8'd1)
      $display("FAIL clr_event: got ovf=%0b cnt=%0d want ovf=1 cnt=1", ovf, hit_cnt);
    else pass_cnt++;
    total_cnt++;
    if (out_ts !== 12'd0) $display("FAIL clr_event_head: got %0d want 0", out_ts); else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (4094) step();
    hit = 1'b1;
    step();
    hit = 1'b0;
    step();
    step();
    hit = 1'b1;
    step();
    hit = 1'b0;
    total_cnt++;
    if (out_ts !== 12'd4094) $display("FAIL wrap_first: got %0d want 4094", out_ts); else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++;
    if (out_valid !== 1'b1 || out_ts !== 12'd1)
      $display("FAIL wrap_second: got valid=%0b ts=%0d want valid=1 ts=1", out_valid, out_ts);
    else pass_cnt++;
    step();
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL wrap_empty: got %0b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (260) pulse();
    total_cnt++;
    if (hit_cnt !== 8'd255) $display("FAIL sat_cnt: got %0d want 255", hit_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse();
    pulse();
    reset = 1'b1;
    hit = 1'b1;
    step();
    step();
    reset = 1'b0;
    hit = 1'b0;
    step();
    total_cnt++;
    if (out_valid !== 1'b0 || out_ts !== 12'd0 || ovf !== 1'b0 || hit_cnt !== 8'd0)
      $display("FAIL reset_mid: got valid=%0b ts=%0d ovf=%0b cnt=%0d want all 0", out_valid, out_ts, ovf, hit_cnt);
    else pass_cnt++;
  endtask

`ifdef SEQ_HIT_LOGGER_IRQ_EN
  task automatic test_irq();
    do_reset();
    pulse();
    hit = 1'b1;
    step();
    hit = 1'b0;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_lag: got %0b want 0", irq); else pass_cnt++;
    step();
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL irq_set: got %0b want 1", irq); else pass_cnt++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL irq_hold: got %0b want 1", irq); else pass_cnt++;
    step();
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_clear: got %0b want 0", irq); else pass_cnt++;
    pulse();
    step();
    reset = 1'b1;
    step();
    total_cnt++;
    if (irq !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL irq_reset: got irq=%0b valid=%0b want 0", irq, out_valid);
    else pass_cnt++;
    reset = 1'b0;
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset = 1'b1; hit = 1'b0; clr = 1'b0; out_ready = 1'b0;
    test_reset();
    test_single_pulse();
    test_held_high();
    test_empty_push_pop();
    test_overflow();
    test_full_push_pop();
    test_clr_with_event();
    test_wrap();
    test_saturate();
    test_reset_mid();
`ifdef SEQ_HIT_LOGGER_IRQ_EN
    test_irq();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
